// File: rtl/morph_pass_sequencer_if.sv
// Bus bundle between the pass sequencer, the ping-pong frame-buffer banks
// and the 3x3 morphology engine. The sequencer uses the master view and the
// memory/engine environment uses the slave view.
interface morph_pass_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
);
    // Control from / status to the pupil-detect top FSM
    logic              start;
    logic [3:0]        num_passes;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [3:0]        pass_idx;

    // Frame-buffer read side
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic [DATA_W-1:0] rd_data;

    // Morphology engine feed and result
    logic              eng_rst_n;
    logic              eng_valid;
    logic [DATA_W-1:0] eng_data;
    logic              eng_out_valid;
    logic [DATA_W-1:0] eng_out_data;

    // Frame-buffer write side
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  start, num_passes, rd_data, eng_out_valid, eng_out_data,
        output busy, done, frame_err, pass_idx,
               rd_en, rd_addr, rd_bank,
               eng_rst_n, eng_valid, eng_data,
               wr_en, wr_addr, wr_bank, wr_data
    );

    modport slave (
        output start, num_passes, rd_data, eng_out_valid, eng_out_data,
        input  busy, done, frame_err, pass_idx,
               rd_en, rd_addr, rd_bank,
               eng_rst_n, eng_valid, eng_data,
               wr_en, wr_addr, wr_bank, wr_data
    );
endinterface

// File: rtl/morph_pass_sequencer.sv
// Sequences the 3x3 morphology engine over a full frame held in two
// ping-pong pixel banks. Each pass streams one bank through the engine,
// drains the window pipeline and writes the results into the other bank.
// The sequence runs num_passes back-to-back passes, then pulses done.
module morph_pass_sequencer #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 17,
    parameter int DRAIN_MAX = 1024
) (
    input  logic                  clock,
    input  logic                  rst_n,
    morph_pass_sequencer_if.master bus
);

    // Pixel counters carry one extra bit so a full-frame count never wraps.
    localparam logic [ADDR_W:0] PIX_N    = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W+1)'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    localparam int              DRAIN_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    state_t             state;
    logic               busy_r;
    logic               done_r;
    logic               frame_err_r;
    logic [3:0]         pass_idx_r;
    logic [3:0]         passes_lat;
    logic               clr_cnt;
    logic               rd_en_r;
    logic [ADDR_W:0]    rd_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               vld_p1;

    logic [ADDR_W:0]    out_cnt;
    logic               wr_en_p1;
    logic [ADDR_W-1:0]  wr_addr_p1;
    logic [DATA_W-1:0]  wr_data_p1;

    // Pass sequencing FSM with its registered control outputs and read counter.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            pass_idx_r  <= 4'd0;
            passes_lat  <= 4'd0;
            clr_cnt     <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_cnt      <= '0;
            drain_cnt   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r      <= 1'b1;
                        frame_err_r <= 1'b0;
                        pass_idx_r  <= 4'd0;
                        passes_lat  <= bus.num_passes;
                        if (bus.num_passes == 4'd0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state   <= CLEAR;
                            clr_cnt <= 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    // Engine is held in reset here; two cycles flush its window.
                    rd_cnt <= '0;
                    if (clr_cnt) begin
                        state   <= STREAM;
                        rd_en_r <= 1'b1;
                    end else begin
                        clr_cnt <= 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_cnt == PIX_LAST) begin
                        rd_en_r   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    // out_cnt reaching PIX_N means the final write is on the bus now.
                    if (out_cnt == PIX_N) begin
                        state <= NEXT;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        frame_err_r <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                    end
                end
                NEXT: begin
                    pass_idx_r <= pass_idx_r + 4'd1;
                    if (pass_idx_r + 4'd1 == passes_lat) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        state   <= CLEAR;
                        clr_cnt <= 1'b0;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-to-engine stage: bank data arrives one cycle after rd_en.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en_r;
        end
    end

    // Engine-result write stage: capture in-frame results, drop any surplus.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            out_cnt    <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= 1'b0;
            if (state == CLEAR) begin
                out_cnt <= '0;
            end else if ((state == STREAM || state == DRAIN) &&
                         bus.eng_out_valid && (out_cnt < PIX_N)) begin
                wr_en_p1   <= 1'b1;
                wr_addr_p1 <= out_cnt[ADDR_W-1:0];
                wr_data_p1 <= bus.eng_out_data;
                out_cnt    <= out_cnt + CNT_ONE;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.frame_err = frame_err_r;
    assign bus.pass_idx  = pass_idx_r;

    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr   = rd_cnt[ADDR_W-1:0];
    assign bus.rd_bank   = pass_idx_r[0];

    assign bus.eng_rst_n = rst_n & (state != CLEAR);
    assign bus.eng_valid = vld_p1;
    assign bus.eng_data  = vld_p1 ? bus.rd_data : '0;

    assign bus.wr_en     = wr_en_p1;
    assign bus.wr_addr   = wr_addr_p1;
    assign bus.wr_bank   = ~pass_idx_r[0];
    assign bus.wr_data   = wr_data_p1;

endmodule
